// File: rtl/fir_tap_sequencer.sv
// Time-multiplexed FIR controller: feeds one shared multiplier with (x[n-k], h[k]) pairs,
// accumulates the returned products and presents y[n] on a valid/ready output.
module fir_tap_sequencer #(
    parameter int DW      = 4,
    parameter int TAPS    = 4,
    parameter int MUL_LAT = 1,
    parameter int PW      = 4*DW + 1,
    parameter int AW      = $clog2(TAPS),
    parameter int ACCW    = PW + AW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [DW-1:0]   in_data,
    output logic            in_ready,
    input  logic            coef_we,
    input  logic [AW-1:0]   coef_addr,
    input  logic [7:0]      coef_wdata,
    output logic            coef_err,
    output logic            mul_en,
    output logic [DW-1:0]   mul_x,
    output logic [3:0]      mul_hsel,
    output logic [3:0]      mul_lsel,
    input  logic [PW-1:0]   mul_p,
    output logic            out_valid,
    output logic [ACCW-1:0] out_data,
    input  logic            out_ready,
    output logic            busy
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_OUT} state_t;

    state_t               r_state;
    logic [AW-1:0]        r_k;
    logic [DW-1:0]        r_x [TAPS];
    logic [7:0]           r_h [TAPS];
    logic [MUL_LAT-1:0]   r_vld;
    logic [ACCW-1:0]      r_acc;
    logic                 r_mul_en;
    logic [DW-1:0]        r_mul_x;
    logic [7:0]           r_mul_h;
    logic                 r_in_ready;
    logic                 r_busy;
    logic                 r_out_valid;
    logic                 r_coef_err;

    logic [AW-1:0]        w_k_next;
    logic [7:0]           w_h0;

    assign w_k_next = r_k + AW'(1);
    // Tap 0 is read on the acceptance edge, so a same-edge coefficient write must be forwarded.
    assign w_h0     = (coef_we && coef_addr == '0) ? coef_wdata : r_h[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_k         <= '0;
            // NOTE: the delay line and coefficient bank are architectural state that must read
            // zero after reset, so they are cleared here rather than left to power-up values.
            for (int i = 0; i < TAPS; i++) begin
                r_x[i] <= '0;
                r_h[i] <= '0;
            end
            r_vld       <= '0;
            r_acc       <= '0;
            r_mul_en    <= 1'b0;
            r_mul_x     <= '0;
            r_mul_h     <= '0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_coef_err  <= 1'b0;
        end else begin
            r_coef_err <= coef_we && (r_state != S_IDLE);
            if (coef_we && r_state == S_IDLE)
                r_h[coef_addr] <= coef_wdata;

            for (int i = MUL_LAT-1; i > 0; i--)
                r_vld[i] <= r_vld[i-1];
            r_vld[0] <= r_mul_en;
            if (r_vld[MUL_LAT-1])
                r_acc <= r_acc + ACCW'(mul_p);

            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_x[0] <= in_data;
                        for (int i = 1; i < TAPS; i++)
                            r_x[i] <= r_x[i-1];
                        r_acc      <= '0;
                        r_k        <= '0;
                        r_mul_en   <= 1'b1;
                        r_mul_x    <= in_data;
                        r_mul_h    <= w_h0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (r_k == AW'(TAPS-1)) begin
                        r_mul_en <= 1'b0;
                        r_mul_x  <= '0;
                        r_mul_h  <= '0;
                        r_state  <= S_DRAIN;
                    end else begin
                        r_k     <= w_k_next;
                        r_mul_x <= r_x[w_k_next];
                        r_mul_h <= r_h[w_k_next];
                    end
                end
                S_DRAIN: begin
                    if (r_vld == '0) begin
                        r_out_valid <= 1'b1;
                        r_state     <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign busy      = r_busy;
    assign coef_err  = r_coef_err;
    assign mul_en    = r_mul_en;
    assign mul_x     = r_mul_x;
    assign mul_hsel  = r_mul_h[7:4];
    assign mul_lsel  = r_mul_h[3:0];
    assign out_valid = r_out_valid;
    assign out_data  = r_acc;

endmodule
